// File: rtl/sdm_fcw_ramp.sv
// Frequency-control-word ramp controller: accepts a range-checked target FCW and
// slews the registered N/frac outputs toward it in bounded steps, then settles.
module sdm_fcw_ramp #(
   parameter int          STEP       = 16,
   parameter int          TICK_DIV   = 8,
   parameter int          SETTLE_CYC = 64,
   parameter int          N_MIN      = 16,
   parameter int          N_MAX      = 60,
   parameter logic [15:0] RST_FCW    = 16'h7800
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [15:0] fcw_in,
   input  logic        fcw_valid,
   output logic        fcw_ready,
   input  logic        hold,
   output logic [5:0]  N,
   output logic [9:0]  frac,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
   localparam logic [15:0]   STEP_W      = 16'(STEP);
   localparam logic [5:0]    N_LO        = 6'(N_MIN);
   localparam logic [5:0]    N_HI        = 6'(N_MAX);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RAMP   = 2'd1,
      ST_SETTLE = 2'd2
   } state_e;

   state_e          state_q,  state_d;
   logic [15:0]     fcw_cur_q, fcw_cur_d;
   logic [15:0]     tgt_q,    tgt_d;
   logic [TW-1:0]   tick_q,   tick_d;
   logic [SW-1:0]   settle_q, settle_d;
   logic            ready_q,  ready_d;
   logic            busy_q,   busy_d;
   logic            done_q,   done_d;
   logic            err_q,    err_d;

   logic [16:0]     diff_s;
   logic [15:0]     mag_s;
   logic            in_range_s;
   logic            accept_s;

   // Next-state and next-output computation for the ramp FSM
   always_comb begin
      state_d    = state_q;
      fcw_cur_d  = fcw_cur_q;
      tgt_d      = tgt_q;
      tick_d     = tick_q;
      settle_d   = settle_q;
      ready_d    = ready_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = 1'b0;

      // diff[16] set means the target lies below the current word
      diff_s     = {1'b0, tgt_q} - {1'b0, fcw_cur_q};
      if (diff_s[16]) begin
         mag_s = fcw_cur_q - tgt_q;
      end else begin
         mag_s = diff_s[15:0];
      end
      in_range_s = (fcw_in[15:10] >= N_LO) && (fcw_in[15:10] <= N_HI);
      accept_s   = fcw_valid & ready_q;

      case (state_q)
         ST_IDLE: begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
            if (accept_s) begin
               if (!in_range_s) begin
                  err_d = 1'b1;
               end else if (fcw_in == fcw_cur_q) begin
                  tgt_d    = fcw_in;
                  settle_d = {SW{1'b0}};
                  state_d  = ST_SETTLE;
                  ready_d  = 1'b0;
                  busy_d   = 1'b1;
               end else begin
                  tgt_d   = fcw_in;
                  tick_d  = {TW{1'b0}};
                  state_d = ST_RAMP;
                  ready_d = 1'b0;
                  busy_d  = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RAMP: begin
            if (hold) begin
               tick_d = tick_q;
            end else if (tick_q == TICK_LAST) begin
               tick_d = {TW{1'b0}};
               if (mag_s <= STEP_W) begin
                  fcw_cur_d = tgt_q;
                  settle_d  = {SW{1'b0}};
                  state_d   = ST_SETTLE;
               end else if (diff_s[16]) begin
                  fcw_cur_d = fcw_cur_q - STEP_W;
               end else begin
                  fcw_cur_d = fcw_cur_q + STEP_W;
               end
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
         ST_SETTLE: begin
            if (hold) begin
               settle_d = settle_q;
            end else if (settle_q == SETTLE_LAST) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               ready_d = 1'b1;
               busy_d  = 1'b0;
            end else begin
               settle_d = settle_q + SW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         fcw_cur_q <= RST_FCW;
         tgt_q     <= RST_FCW;
         tick_q    <= {TW{1'b0}};
         settle_q  <= {SW{1'b0}};
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         fcw_cur_q <= fcw_cur_d;
         tgt_q     <= tgt_d;
         tick_q    <= tick_d;
         settle_q  <= settle_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign N         = fcw_cur_q[15:10];
   assign frac      = fcw_cur_q[9:0];
   assign fcw_ready = ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule
